// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder sequencer. A start pulse in IDLE captures operands a and
//   b; the pair is then fed LSB-first through two half adders plus a carry
//   flip-flop, one bit per clock. Sum bits collect in a right-shifting
//   partial-sum register. After WIDTH bits the registered result is loaded
//   into sum/cout and done pulses for one cycle.
//
//   Ports
//     clk    in   1      clock, rising edge
//     rst_n  in   1      asynchronous reset, active low
//     start  in   1      request, sampled only in IDLE
//     a, b   in   WIDTH  operands, captured on the accepted start edge
//     busy   out  1      high while in ADD
//     done   out  1      one-cycle pulse, result valid from this cycle on
//     sum    out  WIDTH  registered result, held until the next completion
//     cout   out  1      registered carry out of bit WIDTH-1
//
//   Handshake: a request is a single-cycle start level seen in IDLE; it is
//   not acknowledged other than by busy rising on the next cycle. start seen
//   in ADD or DONE is dropped, not queued.
// ---------------------------------------------------------------------------

module half_adder (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Bit datapath: two half adders and an OR form one full-adder step.
    logic s1, c1, s_bit, c2, carry_next;

    half_adder u_ha1 (
        .x_i (a_q[0]),
        .y_i (b_q[0]),
        .s_o (s1),
        .c_o (c1)
    );

    half_adder u_ha2 (
        .x_i (s1),
        .y_i (carry_q),
        .s_o (s_bit),
        .c_o (c2)
    );

    assign carry_next = c1 | c2;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                part_d  = {s_bit, part_q[WIDTH-1:1]};
                carry_d = carry_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // The last sum bit is still in flight, so take it from
                    // the shift input rather than from part_q.
                    sum_d   = {s_bit, part_q[WIDTH-1:1]};
                    cout_d  = carry_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
